idma_obi_write_ot: RTL and testbench



---
 rtl/idma_obi_write_ot.sv | 204 ++++++++++++++++++++
 tb/tb_idma_obi_write_ot.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/idma_obi_write_ot.sv
// iDMA OBI write task: one OBI write beat per datapath request, credit-limited to MaxOutstanding,
// with OBI responses buffered in a registered FIFO so rready is always high.
package idma_obi_write_ot_pkg;
  typedef logic [7:0]   byte_t;
  typedef logic [127:0] data_t;
  typedef logic [15:0]  strb_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    strb_t       be;
    data_t       wdata;
    logic [0:0]  aid;
  } obi_a_chan_t;

  typedef struct packed {
    obi_a_chan_t a;
    logic        req;
    logic        rready;
  } write_req_t;

  typedef struct packed {
    data_t      rdata;
    logic [0:0] rid;
    logic       err;
  } obi_r_chan_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    obi_r_chan_t r;
  } write_rsp_t;

  typedef struct packed {
    logic [3:0] offset;
    logic [3:0] tailer;
  } w_dp_req_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [0:0] user;
  } w_dp_rsp_t;

  typedef struct packed {
    obi_a_chan_t a_chan;
  } obi_meta_t;

  typedef struct packed {
    obi_meta_t obi;
  } write_meta_channel_t;
endpackage

module idma_obi_write_ot #(
  parameter int unsigned StrbWidth       = 16,
  parameter int unsigned MaxOutstanding  = 4,
  parameter bit          MaskInvalidData = 1'b1,
  parameter type byte_t               = idma_obi_write_ot_pkg::byte_t,
  parameter type data_t               = idma_obi_write_ot_pkg::data_t,
  parameter type strb_t               = idma_obi_write_ot_pkg::strb_t,
  parameter type write_req_t          = idma_obi_write_ot_pkg::write_req_t,
  parameter type write_rsp_t          = idma_obi_write_ot_pkg::write_rsp_t,
  parameter type w_dp_req_t           = idma_obi_write_ot_pkg::w_dp_req_t,
  parameter type w_dp_rsp_t           = idma_obi_write_ot_pkg::w_dp_rsp_t,
  parameter type write_meta_channel_t = idma_obi_write_ot_pkg::write_meta_channel_t
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  w_dp_req_t                           w_dp_req_i,
  input  logic                                w_dp_valid_i,
  output logic                                w_dp_ready_o,
  input  logic                                dp_poison_i,
  output w_dp_rsp_t                           w_dp_rsp_o,
  output logic                                w_dp_valid_o,
  input  logic                                w_dp_ready_i,
  input  write_meta_channel_t                 aw_req_i,
  input  logic                                aw_valid_i,
  output logic                                aw_ready_o,
  output write_req_t                          write_req_o,
  input  write_rsp_t                          write_rsp_i,
  input  byte_t [StrbWidth-1:0]               buffer_out_i,
  input  strb_t                               buffer_out_valid_i,
  output strb_t                               buffer_out_ready_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                                busy_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MaxOutstanding);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

  strb_t mask, be;
  data_t wdata;
  logic  ready_to_write, credit_ok, req, issue, push, pop;
  logic [CntW-1:0] outstanding_q, outstanding_d, fifo_cnt_q, fifo_cnt_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [MaxOutstanding-1:0] err_q, err_d;

  logic unused_in;
  assign unused_in = ^{aw_req_i, write_rsp_i};

  // Bytes [offset, tailer) are live; tailer == 0 means the beat runs to the top byte.
  always_comb begin
    mask = strb_t'('1) << w_dp_req_i.offset;
    if (w_dp_req_i.tailer != '0) begin
      mask &= strb_t'('1) >> (StrbWidth - 32'(w_dp_req_i.tailer));
    end
  end

  assign ready_to_write = aw_valid_i & w_dp_valid_i
                        & ((buffer_out_valid_i & mask) == mask)
                        & (buffer_out_valid_i != '0);
  // Registered count only, so response-side ready never reaches the request path.
  assign credit_ok = outstanding_q < MaxCnt;
  assign req       = ready_to_write & credit_ok;
  assign issue     = req & write_rsp_i.gnt;
  assign be        = (req && !dp_poison_i) ? mask : '0;

  assign w_dp_ready_o       = issue;
  assign aw_ready_o         = issue;
  assign buffer_out_ready_o = issue ? mask : '0;

  always_comb begin
    wdata = '0;
    for (int i = 0; i < StrbWidth; i++) begin
      wdata[i*8 +: 8] = (be[i] || !MaskInvalidData) ? buffer_out_i[i] : 8'h00;
    end
  end

  always_comb begin
    write_req_o          = '0;
    write_req_o.a.addr   = aw_req_i.obi.a_chan.addr;
    write_req_o.a.aid    = aw_req_i.obi.a_chan.aid;
    write_req_o.a.we     = 1'b1;
    write_req_o.a.be     = be;
    write_req_o.a.wdata  = wdata;
    write_req_o.req      = req;
    write_req_o.rready   = 1'b1;
  end

  // A response with no credit outstanding has no write to belong to and is discarded.
  assign push = write_rsp_i.rvalid && (outstanding_q != '0);
  assign pop  = (fifo_cnt_q != '0) && w_dp_ready_i;

  always_comb begin
    err_d         = err_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    fifo_cnt_d    = fifo_cnt_q;
    outstanding_d = outstanding_q;
    if (push) begin
      err_d[wr_ptr_q] = write_rsp_i.r.err;
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CntW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CntW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    case ({issue, pop})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      outstanding_q <= '0;
    end else begin
      err_q         <= err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      outstanding_q <= outstanding_d;
    end
  end

  always_comb begin
    w_dp_rsp_o      = '0;
    w_dp_rsp_o.resp = err_q[rd_ptr_q] ? 2'b10 : 2'b00;
  end

  assign w_dp_valid_o  = fifo_cnt_q != '0;
  assign outstanding_o = outstanding_q;
  assign busy_o        = outstanding_q != '0;

`ifndef SYNTHESIS
  a_rvalid_credit : assert property (@(posedge clk_i) disable iff (!rst_ni)
    write_rsp_i.rvalid |-> outstanding_q != '0)
    else $error("OBI rvalid with no outstanding write");
  a_fifo_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    push |-> fifo_cnt_q != MaxCnt)
    else $error("response FIFO push while full");
`endif

endmodule

// File: tb/tb_idma_obi_write_ot.sv
// Directed bench for idma_obi_write_ot (8-byte beats, 4 credits) with a response scoreboard.
module tb_idma_obi_write_ot;
  localparam int SW = 8;
  localparam int MO = 4;

  typedef logic [7:0]  byte_t;
  typedef logic [63:0] data_t;
  typedef logic [7:0]  strb_t;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    strb_t       be;
    data_t       wdata;
    logic [0:0]  aid;
  } a_chan_t;
  typedef struct packed { a_chan_t a; logic req; logic rready; } write_req_t;
  typedef struct packed { data_t rdata; logic [0:0] rid; logic err; } r_chan_t;
  typedef struct packed { logic gnt; logic rvalid; r_chan_t r; } write_rsp_t;
  typedef struct packed { logic [2:0] offset; logic [2:0] tailer; } w_dp_req_t;
  typedef struct packed { logic [1:0] resp; logic [0:0] user; } w_dp_rsp_t;
  typedef struct packed { a_chan_t a_chan; } obi_meta_t;
  typedef struct packed { obi_meta_t obi; } meta_t;

  logic clk = 1'b0, rst_n;
  w_dp_req_t dpq;
  logic dp_v, dp_rdy, poison, rsp_v, rsp_rdy, aw_v, aw_rdy, busy;
  w_dp_rsp_t rsp;
  meta_t aw;
  write_req_t wreq;
  write_rsp_t wrsp;
  byte_t [SW-1:0] buf_d;
  strb_t buf_v, buf_rdy;
  logic [2:0] outst;

  int n_checks = 0, n_fail = 0, pops = 0, issues, pops0;
  logic [1:0] sb[$];

  always #5 clk = ~clk;

  idma_obi_write_ot #(
    .StrbWidth(SW), .MaxOutstanding(MO), .MaskInvalidData(1'b1),
    .byte_t(byte_t), .data_t(data_t), .strb_t(strb_t), .write_req_t(write_req_t),
    .write_rsp_t(write_rsp_t), .w_dp_req_t(w_dp_req_t), .w_dp_rsp_t(w_dp_rsp_t),
    .write_meta_channel_t(meta_t)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .w_dp_req_i(dpq), .w_dp_valid_i(dp_v), .w_dp_ready_o(dp_rdy), .dp_poison_i(poison),
    .w_dp_rsp_o(rsp), .w_dp_valid_o(rsp_v), .w_dp_ready_i(rsp_rdy),
    .aw_req_i(aw), .aw_valid_i(aw_v), .aw_ready_o(aw_rdy),
    .write_req_o(wreq), .write_rsp_i(wrsp),
    .buffer_out_i(buf_d), .buffer_out_valid_i(buf_v), .buffer_out_ready_o(buf_rdy),
    .outstanding_o(outst), .busy_o(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; a response accepted this cycle is compared with the scoreboard head.
  task automatic tick();
    #1;
    if (rsp_v && rsp_rdy) begin
      pops++;
      if (sb.size() == 0) check("sb_underflow", 64'(rsp.resp), 64'hx);
      else check("resp", 64'(rsp.resp), 64'(sb.pop_front()));
      check("user", 64'(rsp.user), 64'h0);
    end
    @(negedge clk);
  endtask

  task automatic rvalid_pulse(input logic err, input logic track);
    wrsp.rvalid = 1'b1;
    wrsp.r.err  = err;
    if (track) sb.push_back(err ? 2'b10 : 2'b00);
    tick();
    wrsp.rvalid = 1'b0;
    wrsp.r.err  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; dpq = '0; dp_v = 0; aw_v = 0; poison = 0; rsp_rdy = 0;
    aw = '0; wrsp = '0; buf_v = '0;
    for (int i = 0; i < SW; i++) buf_d[i] = 8'(8'h11 * (i + 1));
    aw.obi.a_chan.addr = 32'h1000_0040;
    aw.obi.a_chan.aid  = 1'b1;

    @(negedge clk); #1;
    check("rst_outst", 64'(outst), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_rsp_v", 64'(rsp_v), 0);
    check("rst_req", 64'(wreq.req), 0);
    check("rst_be", 64'(wreq.a.be), 0);
    check("rst_bor", 64'(buf_rdy), 0);
    check("rst_rready", 64'(wreq.rready), 1);
    check("rst_wdata", 64'(wreq.a.wdata), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Masked beat: offset 2, tailer 6
    dpq.offset = 3'd2; dpq.tailer = 3'd6; dp_v = 1; aw_v = 1; buf_v = 8'hFF; wrsp.gnt = 1;
    #1;
    check("t1_req", 64'(wreq.req), 1);
    check("t1_be", 64'(wreq.a.be), 64'h3C);
    check("t1_bor", 64'(buf_rdy), 64'h3C);
    check("t1_wdata", 64'(wreq.a.wdata), 64'h0000_6655_4433_0000);
    check("t1_addr", 64'(wreq.a.addr), 64'h1000_0040);
    check("t1_aid", 64'(wreq.a.aid), 1);
    check("t1_we", 64'(wreq.a.we), 1);
    check("t1_dp_rdy", 64'(dp_rdy), 1);
    check("t1_aw_rdy", 64'(aw_rdy), 1);
    tick();
    dp_v = 0; aw_v = 0; #1;
    check("t1_outst", 64'(outst), 1);
    check("t1_busy", 64'(busy), 1);
    check("t1_idle_req", 64'(wreq.req), 0);

    // Response latency: valid one cycle after rvalid
    wrsp.rvalid = 1; wrsp.r.err = 1; sb.push_back(2'b10); #1;
    check("lat_same_cycle", 64'(rsp_v), 0);
    tick();
    wrsp.rvalid = 0; wrsp.r.err = 0; #1;
    check("lat_next_cycle", 64'(rsp_v), 1);
    rsp_rdy = 1; tick(); rsp_rdy = 0; #1;
    check("t1_drained", 64'(outst), 0);
    check("t1_rsp_v_low", 64'(rsp_v), 0);

    // Error then okay, returned in order
    dpq = '0; dp_v = 1; aw_v = 1; tick(); tick(); dp_v = 0; aw_v = 0; #1;
    check("ord_outst", 64'(outst), 2);
    rvalid_pulse(1'b1, 1'b1);
    rvalid_pulse(1'b0, 1'b1);
    rsp_rdy = 1; tick(); tick(); rsp_rdy = 0; #1;
    check("ord_sb_empty", 64'(sb.size()), 0);
    check("ord_outst0", 64'(outst), 0);

    // Credit exhaustion with the response path stalled
    dp_v = 1; aw_v = 1; issues = 0;
    for (int c = 0; c < 6; c++) begin
      #1; issues += int'(dp_rdy);
      tick();
    end
    #1;
    check("stall_issues", 64'(issues), 4);
    check("stall_req", 64'(wreq.req), 0);
    check("stall_outst", 64'(outst), 4);
    for (int k = 0; k < 4; k++) rvalid_pulse(k[0], 1'b1);
    for (int c = 0; c < 10; c++) begin
      #1;
      check("stall_rready", 64'(wreq.rready), 1);
      check("stall_req_hold", 64'(wreq.req), 0);
      tick();
    end
    #1;
    check("stall_rsp_v", 64'(rsp_v), 1);
    pops0 = pops;
    rsp_rdy = 1; #1;
    check("full_pop_req", 64'(wreq.req), 0);
    tick(); #1;
    check("resume_req", 64'(wreq.req), 1);
    check("resume_dp_rdy", 64'(dp_rdy), 1);
    tick();
    dp_v = 0; aw_v = 0;
    tick(); tick(); #1;
    check("release_pops", 64'(pops - pops0), 4);
    check("release_rsp_v", 64'(rsp_v), 0);
    check("release_outst", 64'(outst), 1);
    rvalid_pulse(1'b0, 1'b1);
    tick(); #1;
    check("release_outst0", 64'(outst), 0);
    rsp_rdy = 0;

    // Poisoned beat still issues and consumes a credit
    poison = 1; dp_v = 1; aw_v = 1; #1;
    check("psn_be", 64'(wreq.a.be), 0);
    check("psn_req", 64'(wreq.req), 1);
    check("psn_wdata", 64'(wreq.a.wdata), 0);
    check("psn_bor", 64'(buf_rdy), 64'hFF);
    tick();
    poison = 0; dp_v = 0; aw_v = 0; #1;
    check("psn_outst", 64'(outst), 1);
    rvalid_pulse(1'b0, 1'b1);
    rsp_rdy = 1; tick(); rsp_rdy = 0; #1;
    check("psn_outst0", 64'(outst), 0);

    // Partial buffer valid blocks the request; no grant blocks the handshake
    buf_v = 8'h0F; dp_v = 1; aw_v = 1; #1;
    check("part_req", 64'(wreq.req), 0);
    check("part_dp_rdy", 64'(dp_rdy), 0);
    dpq.tailer = 3'd4; #1;
    check("part_req_tail", 64'(wreq.req), 1);
    check("part_be_tail", 64'(wreq.a.be), 64'h0F);
    wrsp.gnt = 0; #1;
    check("nognt_dp_rdy", 64'(dp_rdy), 0);
    check("nognt_bor", 64'(buf_rdy), 0);
    tick(); #1;
    check("nognt_outst", 64'(outst), 0);
    wrsp.gnt = 1; buf_v = 8'hFF; dpq = '0; dp_v = 0; aw_v = 0;

    // Asynchronous reset with three writes in flight
    dp_v = 1; aw_v = 1; tick(); tick(); tick(); dp_v = 0; aw_v = 0; #1;
    check("prerst_outst", 64'(outst), 3);
    rvalid_pulse(1'b1, 1'b0);
    #1;
    check("prerst_rsp_v", 64'(rsp_v), 1);
    #1 rst_n = 0; #1;
    check("arst_outst", 64'(outst), 0);
    check("arst_rsp_v", 64'(rsp_v), 0);
    check("arst_busy", 64'(busy), 0);
    @(negedge clk); rst_n = 1; tick(); #1;
    check("postrst_rsp_v", 64'(rsp_v), 0);
    check("sb_drained", 64'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
